lmi_dram_xreq: RTL
==================

# lmi_dram_xreq

External-side initiator for the local data RAM's external-access port. It raises `EXT_DWREQRAM_R`, waits for `DW_GNTRAM_R`, and moves a programmed block of 32-bit words between the RAM and a host-side valid/ready stream. Reads go from RAM to the stream; writes go from the stream to RAM. A small FIFO sits between the two sides, so a revoked grant or a stalled stream never drops or duplicates a word.

## Interface
- `DATA_INDEX_HI`, 13: MSB of the word index driven to the RAM.
- `DATA_INDEX_LO`, 2: LSB of the word index (word-aligned).
- `CNT_W`, 12: width of the word counter.
- `FIFO_DEPTH`, 4: staging FIFO entries (power of two, ≥2).
- `CLK` in 1: the single clock.
- `RESET_D1_R` in 1: reset, synchronous, active-high.
- `START` in 1: one-cycle pulse that launches a transfer; ignored unless the block is in IDLE.
- `DIR` in 1: 0 = RAM read (RAM to OUT stream), 1 = RAM write (IN stream to RAM); sampled with `START`.
- `START_INDEX` in [DATA_INDEX_HI:DATA_INDEX_LO]: first word index; sampled with `START`.
- `WORDS` in CNT_W: number of words to move; sampled with `START`.
- `BUSY` out 1: high from the cycle after an accepted `START` through the DONE state.
- `DONE` out 1: one-cycle completion pulse.
- `EXT_DWREQRAM_R` out 1: registered request for the RAM port.
- `DW_GNTRAM_R` in 1: grant; may drop in any cycle.
- `XR_DATAINDEX` out [DATA_INDEX_HI:DATA_INDEX_LO]: RAM word index.
- `XR_DATAWR` out 32: write data.
- `XR_DATAWE` out 1: write enable.
- `XR_DATARE` out 1: read enable.
- `XR_DATACS` out 1: chip select.
- `DWR_DATARD` in 32: RAM read data, valid the cycle after `XR_DATARE`.
- `IN_VALID` in 1, `IN_DATA` in 32, `IN_READY` out 1: host write stream.
- `OUT_VALID` out 1, `OUT_DATA` out 32, `OUT_READY` in 1: host read stream.

## Operation
- States: IDLE, XFER, FLUSH, DONE.
- IDLE → XFER on `START`:
  - latch `DIR`, the index and `WORDS`;
  - clear the counters `issued`, `returned` and `moved`;
  - if `WORDS`=0, go IDLE → DONE directly and never raise the request.
- XFER:
  - `EXT_DWREQRAM_R`=1.
  - An access issues in a cycle only when `DW_GNTRAM_R`=1, `issued`<`WORDS` and the direction's condition holds.
  - Each issue drives `XR_DATACS` plus `XR_DATARE` or `XR_DATAWE` for that one cycle and increments the index.
  - The index wraps modulo 2^(DATA_INDEX_HI-DATA_INDEX_LO+1).
- Read condition: FIFO occupancy + in-flight reads < `FIFO_DEPTH`. Each read's `DWR_DATARD` is pushed into the FIFO the following cycle, even if the grant has dropped. `OUT_*` presents the FIFO head.
- Write condition: FIFO not empty. The FIFO head drives `XR_DATAWR` and is popped on issue. `IN_READY` = FIFO not full AND accepted words < `WORDS`.
- XFER → FLUSH when `issued`=`WORDS`. `EXT_DWREQRAM_R` drops in that transition; in FLUSH no RAM strobes are driven.
- FLUSH → DONE:
  - Read: last read data returned and FIFO drained by `OUT` handshakes.
  - Write: immediately, because the last write already issued.
- DONE: `DONE`=1 for one cycle, then → IDLE.
- `START` in any state other than IDLE is ignored.
- Reset (at any point, including mid-transfer): state IDLE, FIFO emptied, counters cleared. In-flight read data is discarded. No `DONE` pulse.

## Timing
- Reset values: all outputs 0, including `IN_READY`, `OUT_VALID` and the index.
- `START` accepted at edge N: `BUSY`=1 and `EXT_DWREQRAM_R`=1 from cycle N+1. The first access is driven in the first cycle ≥N+1 in which `DW_GNTRAM_R`=1.
- RAM strobes are combinational from registered state and `DW_GNTRAM_R`. `DW_GNTRAM_R` low in a cycle means no strobe in that cycle.
- Sustained throughput is 1 word/cycle while the grant holds and the stream never stalls: read needs `OUT_READY`=1, write needs `IN_VALID`=1.
- Read latency: `XR_DATARE` in cycle k, FIFO push in k+1, `OUT_VALID` earliest in k+2.
- Simultaneous FIFO push and pop in one cycle are both honoured and occupancy is unchanged. A pop from a full FIFO frees the slot in the same cycle for the purposes of `IN_READY`.

## Test plan
- Read: `DIR`=0, `START_INDEX`=0x10, `WORDS`=8, grant tied high, `OUT_READY`=1. Expected:
  - `XR_DATARE` for 8 consecutive cycles, indices 0x10–0x17;
  - 8 `OUT` words in RAM order;
  - `DONE` pulses once and `EXT_DWREQRAM_R` low afterwards.
- Write with a gappy stream: `DIR`=1, `WORDS`=5, `IN_VALID` toggling. Expected: exactly 5 `XR_DATAWE` pulses carrying the `IN_DATA` values in order; `IN_READY`=0 after the fifth accept.
- Grant revoked: `WORDS`=6, `DW_GNTRAM_R` low for 3 cycles after the second read. Expected:
  - no strobes during the gap;
  - the second word is still pushed;
  - all 6 words delivered exactly once.
- Back-pressure: read with `WORDS`=10, `OUT_READY`=0 for 10 cycles. Expected: reads stop after 4 outstanding (depth 4), then resume; no data lost.
- Wrap and zero:
  - `START_INDEX`=max index, `WORDS`=3 → indices max, 0, 1;
  - `WORDS`=0 → `DONE` pulses 1 cycle after `START`, `EXT_DWREQRAM_R` never asserts.
- Reset mid-read after 3 of 8 words: `RESET_D1_R`=1 for 1 cycle. Expected:
  - next cycle all outputs 0 and no `DONE` pulse;
  - a new `START` runs correctly.

Source files
------------

// File: rtl/lmi_dram_xreq.sv
// lmi_dram_xreq
//   External-side initiator for the local data RAM's external-access port.
//   Requests the port, waits for the grant and moves WORDS 32-bit words
//   between the RAM and a host valid/ready stream through a small FIFO.
//   DIR=0 reads RAM into the OUT stream; DIR=1 writes the IN stream to RAM.
//
// Ports
//   CLK, RESET_D1_R                 clock, synchronous active-high reset
//   START, DIR, START_INDEX, WORDS  transfer launch (sampled in IDLE only)
//   BUSY, DONE                      status / one-cycle completion pulse
//   EXT_DWREQRAM_R, DW_GNTRAM_R     RAM port request / grant
//   XR_DATAINDEX, XR_DATAWR,
//   XR_DATAWE, XR_DATARE, XR_DATACS RAM access strobes (combinational)
//   DWR_DATARD                      RAM read data, one cycle after XR_DATARE
//   IN_VALID, IN_DATA, IN_READY     host write stream
//   OUT_VALID, OUT_DATA, OUT_READY  host read stream
//
// state  | meaning
// IDLE   | waiting for START
// XFER   | request raised, accesses issue while granted
// FLUSH  | all accesses issued, draining read data
// DONE   | one-cycle completion pulse
module lmi_dram_xreq #(
  parameter int DATA_INDEX_HI = 13,
  parameter int DATA_INDEX_LO = 2,
  parameter int CNT_W         = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                               CLK,
  input  logic                               RESET_D1_R,
  input  logic                               START,
  input  logic                               DIR,
  input  logic [DATA_INDEX_HI:DATA_INDEX_LO] START_INDEX,
  input  logic [CNT_W-1:0]                   WORDS,
  output logic                               BUSY,
  output logic                               DONE,
  output logic                               EXT_DWREQRAM_R,
  input  logic                               DW_GNTRAM_R,
  output logic [DATA_INDEX_HI:DATA_INDEX_LO] XR_DATAINDEX,
  output logic [31:0]                        XR_DATAWR,
  output logic                               XR_DATAWE,
  output logic                               XR_DATARE,
  output logic                               XR_DATACS,
  input  logic [31:0]                        DWR_DATARD,
  input  logic                               IN_VALID,
  input  logic [31:0]                        IN_DATA,
  output logic                               IN_READY,
  output logic                               OUT_VALID,
  output logic [31:0]                        OUT_DATA,
  input  logic                               OUT_READY
);

  localparam int IW = DATA_INDEX_HI - DATA_INDEX_LO + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                         state_q, state_d;
  logic                               dir_q, dir_d;
  logic [DATA_INDEX_HI:DATA_INDEX_LO] idx_q, idx_d;
  logic [CNT_W-1:0]                   words_q, words_d;
  logic [CNT_W-1:0]                   issued_q, issued_d;
  logic [CNT_W-1:0]                   returned_q, returned_d;
  logic [CNT_W-1:0]                   moved_q, moved_d;
  logic                               req_q, req_d;
  logic                               rd_pend_q, rd_pend_d;
  logic [PW-1:0]                      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0]                      occ_q, occ_d;
  logic [31:0]                        mem_q [FIFO_DEPTH];

  logic        fifo_empty, fifo_full, rd_room, issue, push, pop;
  logic [31:0] head, push_data;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OCC_FULL);
  // a read may only issue if its data is guaranteed a slot on return
  assign rd_room    = (occ_q + OW'(rd_pend_q)) < OCC_FULL;
  assign head       = mem_q[rptr_q];

  assign issue = (state_q == S_XFER) && DW_GNTRAM_R && (issued_q < words_q) &&
                 (dir_q ? !fifo_empty : rd_room);

  assign XR_DATACS    = issue;
  assign XR_DATARE    = issue & ~dir_q;
  assign XR_DATAWE    = issue & dir_q;
  assign XR_DATAINDEX = idx_q;
  assign XR_DATAWR    = XR_DATAWE ? head : '0;

  assign OUT_VALID = ~dir_q & ~fifo_empty;
  assign OUT_DATA  = OUT_VALID ? head : '0;

  assign pop = dir_q ? XR_DATAWE : (OUT_VALID & OUT_READY);
  // a write issuing this cycle frees its slot for a same-cycle accept
  assign IN_READY = dir_q && (state_q == S_XFER) && (!fifo_full || pop) &&
                    (moved_q < words_q);

  // read data is pushed the cycle after its strobe regardless of the grant
  assign push      = dir_q ? (IN_VALID & IN_READY) : rd_pend_q;
  assign push_data = dir_q ? IN_DATA : DWR_DATARD;

  assign BUSY           = (state_q != S_IDLE);
  assign DONE           = (state_q == S_DONE);
  assign EXT_DWREQRAM_R = req_q;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    idx_d      = idx_q;
    words_d    = words_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    moved_d    = moved_q;

    if (push && !dir_q) returned_d = returned_q + CNT_W'(1);
    if (dir_q ? push : pop) moved_d = moved_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (START) begin
          dir_d      = DIR;
          idx_d      = START_INDEX;
          words_d    = WORDS;
          issued_d   = '0;
          returned_d = '0;
          moved_d    = '0;
          state_d    = (WORDS == '0) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (issue) begin
          issued_d = issued_q + CNT_W'(1);
          idx_d    = idx_q + IW'(1);
        end
        if (issued_d == words_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (dir_q || (returned_q == words_q && fifo_empty)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_pend_d = issue & ~dir_q;
    req_d     = (state_d == S_XFER);

    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET_D1_R) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      idx_q      <= '0;
      words_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      moved_q    <= '0;
      req_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      idx_q      <= idx_d;
      words_q    <= words_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      moved_q    <= moved_d;
      req_q      <= req_d;
      rd_pend_q  <= rd_pend_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
    end
  end

  // storage needs no reset; the pointers and occupancy define validity
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

endmodule
